multicycle_control: RTL
=======================

// Module: multicycle_control
// PURPOSE
//  Multi-cycle LEGv8 control FSM; successor to the single-cycle combinational decoder. Sequences FETCH/DECODE/EXEC/MEM/WB
//  per instruction, handshakes with variable-latency instruction and data memories, and counts retired instructions.
//  Sits between the IR/datapath and the memories in the multicycle core.
// PARAMETERS
//  OPCODE_W     11  opcode field width (instr[31:21])
//  MEM_TIMEOUT  15  max cycles in MEM waiting for dmem_ready before fault (>=1)
//  CNT_W        32  width of retired-instruction counter
// PORTS
//  clk                 in   1        rising-edge clock
//  reset               in   1        synchronous, active-high
//  opcode              in   OPCODE_W IR opcode field, valid from DECODE onward
//  zero                in   1        ALU zero flag, valid in BRANCH
//  imem_ready          in   1        instruction word valid this cycle
//  dmem_ready          in   1        data access complete this cycle
//  imem_req            out  1        instruction fetch request
//  ir_write            out  1        load IR
//  dmem_read           out  1        data memory read strobe
//  dmem_write          out  1        data memory write strobe
//  readreg2_control    out  1        1 = read-reg-2 from Rt field (STUR/CBZ/CBNZ)
//  alu_src             out  1        1 = immediate operand
//  alu_op              out  2        00 add, 01 pass/compare, 10 R-type funct
//  mem_to_reg          out  1        writeback source = memory
//  reg_write           out  1        register file write enable
//  pc_write            out  1        update PC (one pulse per instruction)
//  pc_src              out  1        1 = branch target, 0 = PC+4; valid with pc_write
//  illegal_op          out  1        1-cycle pulse: undecodable opcode skipped
//  mem_fault           out  1        1-cycle pulse: MEM timeout
//  state               out  3        current state encoding (debug)
//  retired             out  CNT_W    count of pc_write pulses
// BEHAVIOUR
//  Reset: state<=FETCH, class<=NONE, wait_cnt<=0, retired<=0. All outputs Moore-decoded from registered state/class;
//   while reset is high every control output is forced 0. Reset in any state (incl. mid-MEM) aborts the instruction.
//  FETCH: imem_req=1. imem_ready=1 -> ir_write=1 same cycle, next DECODE; else stay.
//  DECODE: latch class from opcode (casex): ADD/SUB/AND/ORR->RTYPE; LDUR/LDURB/LDURH/LDURSW->LOAD; STUR->STORE;
//   CBZ/CBNZ/B->CBZ/CBNZ/B. RTYPE->EXEC_R; LOAD/STORE->EXEC_A; branches->BRANCH.
//   Unknown opcode -> illegal_op=1, pc_write=1, pc_src=0, next FETCH (instruction skipped, still counted).
//  EXEC_R: alu_src=0, alu_op=10 -> WB.   EXEC_A: alu_src=1, alu_op=00, readreg2_control=(STORE) -> MEM, wait_cnt<=0.
//  MEM: dmem_read=LOAD, dmem_write=STORE, held steady until dmem_ready. On dmem_ready: LOAD->WB; STORE->pc_write=1,
//   pc_src=0 -> FETCH. No ready: wait_cnt++; when wait_cnt==MEM_TIMEOUT-1 and still no ready -> mem_fault=1,
//   pc_write=1, pc_src=0 -> FETCH (strobes drop next cycle). dmem_ready on the last allowed cycle wins over fault.
//  WB: reg_write=1, mem_to_reg=(LOAD), pc_write=1, pc_src=0 -> FETCH.
//  BRANCH: alu_op=01, readreg2_control=1 for CBZ/CBNZ; pc_write=1; pc_src = B ? 1 : CBZ ? zero : CBNZ ? ~zero : 0 -> FETCH.
//  Latency (ready same cycle): R-type 4, load 5, store 4, branch 3, illegal 2 cycles.
//  retired increments on every pc_write cycle, wraps modulo 2^CNT_W.
//  Outputs not listed for a state are 0. dmem_read and dmem_write never both 1; pc_write exactly once per instruction.
// STRUCTURE
//  constants.vh: opcode casex patterns, state encodings (FETCH..BRANCH), instruction class codes, alu_op codes.
//  Sub-module opcode_class_decode (combinational opcode -> class + legal flag); FSM, timeout counter, retire counter here.
// TESTING
//  1 ADD 10001011000, imem/dmem ready tied 1 -> FETCH,DECODE,EXEC_R,WB; reg_write=1 in WB only; retired=1 after 4 cycles.
//  2 LDUR 11111000010, dmem_ready after 3 MEM cycles -> dmem_read high 3 cycles, then WB with mem_to_reg=1, reg_write=1.
//  3 STUR 11111000000, dmem_ready=0, MEM_TIMEOUT=15 -> dmem_write 15 cycles, mem_fault pulse, pc_write, back to FETCH.
//  4 CBZ 10110100xxx zero=1 -> pc_src=1; zero=0 -> pc_src=0; CBNZ inverse; B 000101xxxxx -> pc_src=1, no reg_write.
//  5 opcode 11111111111 -> illegal_op pulse in DECODE, pc_write=1, no reg_write/dmem strobe, next FETCH.
//  6 reset asserted in MEM cycle 2 of a load -> next cycle state=FETCH, strobes 0, retired=0; no reg_write ever issued.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared types for the multicycle LEGv8 control FSM: state encodings,
// instruction classes, ALU operation codes and the branch resolution rule.
package multicycle_control_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC_R = 3'd2,
    S_EXEC_A = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_BRANCH = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    C_NONE  = 3'd0,
    C_RTYPE = 3'd1,
    C_LOAD  = 3'd2,
    C_STORE = 3'd3,
    C_CBZ   = 3'd4,
    C_CBNZ  = 3'd5,
    C_B     = 3'd6
  } iclass_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_PASS  = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;

  // Unconditional branches always take the target; CBZ/CBNZ follow the ALU zero flag.
  function automatic logic branch_taken(input iclass_t cls, input logic zero);
    case (cls)
      C_B:     branch_taken = 1'b1;
      C_CBZ:   branch_taken = zero;
      C_CBNZ:  branch_taken = ~zero;
      default: branch_taken = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_decode.sv
// Combinational opcode classifier: maps the 11-bit LEGv8 opcode field to an
// instruction class and flags opcodes the control FSM cannot sequence.
module multicycle_control_decode
  import multicycle_control_pkg::*;
#(
  parameter int OPCODE_W = 11
) (
  input  logic [OPCODE_W-1:0] opcode,
  output iclass_t             cls,
  output logic                legal
);

  // Low opcode bits of CB/B formats carry immediate bits, hence the wildcards.
  always_comb begin
    cls   = C_NONE;
    legal = 1'b1;
    casez (opcode)
      11'b10001011000,
      11'b11001011000,
      11'b10001010000,
      11'b10101010000: cls = C_RTYPE;
      11'b11111000010,
      11'b00111000010,
      11'b01111000010,
      11'b10111000100: cls = C_LOAD;
      11'b11111000000: cls = C_STORE;
      11'b10110100???: cls = C_CBZ;
      11'b10110101???: cls = C_CBNZ;
      11'b000101?????: cls = C_B;
      default:         legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle LEGv8 control FSM: sequences each instruction through its states,
// handshakes with variable-latency memories and counts retired instructions.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int OPCODE_W    = 11,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  output logic                imem_req,
  output logic                ir_write,
  output logic                dmem_read,
  output logic                dmem_write,
  output logic                readreg2_control,
  output logic                alu_src,
  output logic [1:0]          alu_op,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                pc_write,
  output logic                pc_src,
  output logic                illegal_op,
  output logic                mem_fault,
  output logic [2:0]          state,
  output logic [CNT_W-1:0]    retired
);

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  state_t              state_r;
  state_t              state_next;
  iclass_t             class_r;
  iclass_t             dec_class;
  logic                dec_legal;
  logic [WAIT_W-1:0]   wait_cnt_r;
  logic                at_limit;
  logic [CNT_W-1:0]    retired_r;

  multicycle_control_decode #(.OPCODE_W(OPCODE_W)) u_decode (
    .opcode (opcode),
    .cls    (dec_class),
    .legal  (dec_legal)
  );

  assign at_limit = (wait_cnt_r == WAIT_W'(MEM_TIMEOUT - 1));
  assign state    = state_r;
  assign retired  = retired_r;

  // State, latched class, MEM wait counter and retire counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= S_FETCH;
      class_r    <= C_NONE;
      wait_cnt_r <= '0;
      retired_r  <= '0;
    end else begin
      state_r <= state_next;
      if (state_r == S_DECODE) begin
        class_r <= dec_legal ? dec_class : C_NONE;
      end
      if (state_r == S_EXEC_A) begin
        wait_cnt_r <= '0;
      end else if (state_r == S_MEM && !dmem_ready && !at_limit) begin
        wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
      end
      if (pc_write) begin
        retired_r <= retired_r + CNT_W'(1);
      end
    end
  end

  // Next-state and control decode; reset silences every control output.
  always_comb begin
    state_next       = state_r;
    imem_req         = 1'b0;
    ir_write         = 1'b0;
    dmem_read        = 1'b0;
    dmem_write       = 1'b0;
    readreg2_control = 1'b0;
    alu_src          = 1'b0;
    alu_op           = ALU_ADD;
    mem_to_reg       = 1'b0;
    reg_write        = 1'b0;
    pc_write         = 1'b0;
    pc_src           = 1'b0;
    illegal_op       = 1'b0;
    mem_fault        = 1'b0;
    case (state_r)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write   = 1'b1;
          state_next = S_DECODE;
        end else begin
          state_next = S_FETCH;
        end
      end
      S_DECODE: begin
        if (!dec_legal) begin
          illegal_op = 1'b1;
          pc_write   = 1'b1;
          state_next = S_FETCH;
        end else begin
          case (dec_class)
            C_RTYPE:             state_next = S_EXEC_R;
            C_LOAD, C_STORE:     state_next = S_EXEC_A;
            C_CBZ, C_CBNZ, C_B:  state_next = S_BRANCH;
            default:             state_next = S_FETCH;
          endcase
        end
      end
      S_EXEC_R: begin
        alu_op     = ALU_RTYPE;
        state_next = S_WB;
      end
      S_EXEC_A: begin
        alu_src          = 1'b1;
        readreg2_control = (class_r == C_STORE);
        state_next       = S_MEM;
      end
      S_MEM: begin
        dmem_read  = (class_r == C_LOAD);
        dmem_write = (class_r == C_STORE);
        // A ready on the final allowed cycle completes the access instead of faulting.
        if (dmem_ready) begin
          if (class_r == C_LOAD) begin
            state_next = S_WB;
          end else begin
            pc_write   = 1'b1;
            state_next = S_FETCH;
          end
        end else if (at_limit) begin
          mem_fault  = 1'b1;
          pc_write   = 1'b1;
          state_next = S_FETCH;
        end else begin
          state_next = S_MEM;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (class_r == C_LOAD);
        pc_write   = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_op           = ALU_PASS;
        readreg2_control = (class_r == C_CBZ) || (class_r == C_CBNZ);
        pc_write         = 1'b1;
        pc_src           = branch_taken(class_r, zero);
        state_next       = S_FETCH;
      end
      default: begin
        state_next = S_FETCH;
      end
    endcase
    if (reset) begin
      imem_req         = 1'b0;
      ir_write         = 1'b0;
      dmem_read        = 1'b0;
      dmem_write       = 1'b0;
      readreg2_control = 1'b0;
      alu_src          = 1'b0;
      alu_op           = ALU_ADD;
      mem_to_reg       = 1'b0;
      reg_write        = 1'b0;
      pc_write         = 1'b0;
      pc_src           = 1'b0;
      illegal_op       = 1'b0;
      mem_fault        = 1'b0;
    end else begin
      state_next = state_next;
    end
  end

endmodule
